// File: rtl/shift_reg4_seq.sv
// shift_reg4_seq: command sequencer for one shift_reg4 datapath.
// A command optionally preloads the register, then issues N single-bit shifts.
// The final register contents come back on a valid/ready response port.
module shift_reg4_seq #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [AMT_W-1:0] cmd_amt,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             sr_enable,
  output logic [1:0]       sr_dir,
  output logic [WIDTH-1:0] sr_data_in,
  input  logic [WIDTH-1:0] sr_data_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [AMT_W-1:0] MAX_AMT  = AMT_W'(WIDTH);
  localparam logic [1:0]       DIR_LOAD = 2'b11;
  localparam logic [1:0]       DIR_LEFT = 2'b00;
  localparam logic [1:0]       DIR_RGHT = 2'b10;
  localparam logic [1:0]       DIR_IDLE = 2'b01;

  state_t           state_q, state_d;
  logic             right_q, right_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [AMT_W-1:0] amt_clamped;

  logic             cmd_ready_d;
  logic             rsp_valid_d;
  logic             sr_enable_d;
  logic [1:0]       sr_dir_d;
  logic [WIDTH-1:0] sr_data_in_d;

  // Shift counts beyond the register width would only refill zeros, so cap them.
  assign amt_clamped = (cmd_amt > MAX_AMT) ? MAX_AMT : cmd_amt;

  // State and latched command fields; reset aborts any command in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      right_q <= 1'b0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      right_q <= right_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  // Next-state logic: accept in IDLE, one LOAD cycle, cnt_q SHIFT cycles, hold DONE.
  always_comb begin
    state_d = state_q;
    right_d = right_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          right_d = cmd_op[0];
          cnt_d   = amt_clamped;
          data_d  = cmd_op[1] ? cmd_data : '0;
          if (cmd_op[1])
            state_d = LOAD;
          else if (amt_clamped != '0)
            state_d = SHIFT;
          else
            state_d = DONE;
        end
      end
      LOAD: begin
        state_d = (cnt_q != '0) ? SHIFT : DONE;
      end
      SHIFT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= AMT_W'(1))
          state_d = DONE;
      end
      DONE: begin
        if (rsp_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the upcoming state so every pin is driven straight from a flop.
  always_comb begin
    cmd_ready_d  = 1'b0;
    rsp_valid_d  = 1'b0;
    sr_enable_d  = 1'b0;
    sr_dir_d     = DIR_IDLE;
    sr_data_in_d = '0;
    case (state_d)
      IDLE: cmd_ready_d = 1'b1;
      LOAD: begin
        sr_enable_d  = 1'b1;
        sr_dir_d     = DIR_LOAD;
        sr_data_in_d = data_d;
      end
      SHIFT: begin
        sr_enable_d = 1'b1;
        sr_dir_d    = right_d ? DIR_RGHT : DIR_LEFT;
      end
      DONE: rsp_valid_d = 1'b1;
      default: cmd_ready_d = 1'b0;
    endcase
  end

  // Output register; reset values match the IDLE decode with the register parked.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      sr_enable  <= 1'b0;
      sr_dir     <= DIR_IDLE;
      sr_data_in <= '0;
    end else begin
      cmd_ready  <= cmd_ready_d;
      rsp_valid  <= rsp_valid_d;
      sr_enable  <= sr_enable_d;
      sr_dir     <= sr_dir_d;
      sr_data_in <= sr_data_in_d;
    end
  end

  // The register is frozen in DONE, so passing its output through is stable.
  assign rsp_data = rsp_valid ? sr_data_out : '0;

endmodule

// File: tb/tb_shift_reg4_seq.sv
// Testbench for shift_reg4_seq with a behavioural shift register attached.
module tb_shift_reg4_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_amt = 4'd0;
  logic [7:0] cmd_data = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_data;
  logic       sr_enable;
  logic [1:0] sr_dir;
  logic [7:0] sr_data_in;
  logic [7:0] sr_data_out;
  logic [7:0] sr_q = 8'h00;

  typedef struct {
    logic [7:0] data;
    int         k;
    int         acc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   in_rsp = 0;

  shift_reg4_seq #(.WIDTH(8), .AMT_W(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_amt(cmd_amt), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .sr_enable(sr_enable), .sr_dir(sr_dir), .sr_data_in(sr_data_in),
    .sr_data_out(sr_data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Controlled shift register: load/left/right/hold, zero fill, not reset by the sequencer.
  always @(posedge clk) begin
    if (sr_enable) begin
      case (sr_dir)
        2'b11: sr_q <= sr_data_in;
        2'b00: sr_q <= sr_q << 1;
        2'b10: sr_q <= sr_q >> 1;
        default: sr_q <= sr_q;
      endcase
    end
  end
  assign sr_data_out = sr_q;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: checks response latency at rise and data at the handshake.
  always @(negedge clk) begin
    if (!reset) begin
      in_rsp = 0;
    end else begin
      if (rsp_valid && !in_rsp) begin
        in_rsp = 1;
        if (sb.size() == 0) begin
          checkOutput("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          checkOutput("rsp_latency", cyc - sb[0].acc + 1, sb[0].k);
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() > 0) begin
          checkOutput("rsp_data", {24'h0, rsp_data}, {24'h0, sb[0].data});
          void'(sb.pop_front());
        end
        in_rsp = 0;
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] op, input logic [3:0] amt,
                               input logic [7:0] data, input int k,
                               input logic [7:0] exp_data);
    bit   done = 0;
    exp_t e;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_amt   = amt;
    cmd_data  = data;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        e.data = exp_data;
        e.k    = k;
        e.acc  = cyc + 1;
        sb.push_back(e);
        done = 1;
      end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
    if (!done) checkOutput("accept_timeout", 32'd1, 32'd0);
  endtask

  task automatic checkDrive(input logic en, input logic [1:0] dir, input logic [7:0] din);
    checkOutput("sr_enable", {31'h0, sr_enable}, {31'h0, en});
    checkOutput("sr_dir", {30'h0, sr_dir}, {30'h0, dir});
    checkOutput("sr_data_in", {24'h0, sr_data_in}, {24'h0, din});
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !in_rsp) break;
    end
    checkOutput("drain", sb.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int seen;
    // Reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_cmd_ready", {31'h0, cmd_ready}, 32'd1);
    checkOutput("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    checkDrive(1'b0, 2'b01, 8'h00);

    // Preload 0xB5, shift left 3 -> 0xA8
    rsp_ready = 1'b1;
    applyStimulus(2'b10, 4'd3, 8'hB5, 5, 8'hA8);
    @(negedge clk); checkDrive(1'b1, 2'b11, 8'hB5);
    repeat (3) begin
      @(negedge clk); checkDrive(1'b1, 2'b00, 8'h00);
    end
    waitDrain();

    // Shift right 2: 0xA8 -> 0x2A
    applyStimulus(2'b01, 4'd2, 8'h00, 3, 8'h2A);
    repeat (2) begin
      @(negedge clk); checkDrive(1'b1, 2'b10, 8'h00);
    end
    waitDrain();

    // Clamped amount and zero amount
    applyStimulus(2'b11, 4'd12, 8'hFF, 10, 8'h00);
    @(negedge clk); checkDrive(1'b1, 2'b11, 8'hFF);
    waitDrain();
    applyStimulus(2'b00, 4'd0, 8'h00, 1, 8'h00);
    waitDrain();

    // Back-pressure with a second command waiting
    rsp_ready = 1'b0;
    applyStimulus(2'b10, 4'd1, 8'h3C, 3, 8'h78);
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_amt   = 4'd1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    for (int i = 0; i < 4; i++) begin
      checkOutput("hold_rsp_valid", {31'h0, rsp_valid}, 32'd1);
      checkOutput("hold_rsp_data", {24'h0, rsp_data}, 32'h78);
      checkOutput("hold_cmd_ready", {31'h0, cmd_ready}, 32'd0);
      checkOutput("hold_sr_enable", {31'h0, sr_enable}, 32'd0);
      if (i < 3) @(negedge clk);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    applyStimulus(2'b01, 4'd1, 8'h00, 2, 8'h3C);
    waitDrain();

    // Reset in the middle of a 6-shift command
    applyStimulus(2'b10, 4'd6, 8'hFF, 8, 8'h00);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checkOutput("abort_cmd_ready", {31'h0, cmd_ready}, 32'd1);
    checkOutput("abort_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    checkOutput("abort_rsp_data", {24'h0, rsp_data}, 32'd0);
    checkDrive(1'b0, 2'b01, 8'h00);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    checkOutput("no_rsp_after_reset", seen, 32'd0);
    applyStimulus(2'b00, 4'd0, 8'h00, 1, 8'hFE);
    waitDrain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
